// File: rtl/sr_flag_arbiter.sv
// Bank of set/reset status flags shared by NREQ requesters through a round-robin
// arbiter that applies one command per cycle, plus a sequencer that clears the whole bank.
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_op,
  input  logic [NREQ*IW-1:0] req_idx,
  output logic [NREQ-1:0]    req_ready,
  input  logic               sweep_start,
  output logic               sweep_busy,
  output logic               sweep_done,
  output logic [NFLAG-1:0]   flag_q,
  output logic               cmd_valid,
  output logic               cmd_op,
  output logic [IW-1:0]      cmd_idx,
  output logic               err_idx
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW:0]   NF_LIM = (IW+1)'(NFLAG);
  localparam logic [IW-1:0] LAST   = IW'(NFLAG - 1);
  localparam logic [PW-1:0] LAST_R = PW'(NREQ - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [IW-1:0] cnt;

  logic [IW-1:0] idx_arr [NREQ];
  logic [NREQ-1:0] grant_p0;
  logic [PW-1:0] gnt_id_p0;
  logic          vld_p0;
  logic          gnt_op_p0;
  logic [IW-1:0] gnt_idx_p0;
  logic          in_range_p0;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      idx_arr[i] = req_idx[i*IW +: IW];
    end
  end

  // Stage 0: round-robin search starting at ptr; sweep activity or reset blocks all grants
  always_comb begin
    int j;
    logic [PW-1:0] sel;
    j         = 0;
    sel       = '0;
    grant_p0  = '0;
    gnt_id_p0 = '0;
    vld_p0    = 1'b0;
    if (!rst && state == IDLE && !sweep_start) begin
      for (int k = 0; k < NREQ; k++) begin
        j = int'(ptr) + k;
        if (j >= NREQ) j = j - NREQ;
        sel = PW'(j);
        if (!vld_p0 && req_valid[sel]) begin
          vld_p0    = 1'b1;
          gnt_id_p0 = sel;
        end
      end
      if (vld_p0) grant_p0[gnt_id_p0] = 1'b1;
    end
  end

  assign req_ready   = grant_p0;
  assign gnt_op_p0   = req_op[gnt_id_p0];
  assign gnt_idx_p0  = idx_arr[gnt_id_p0];
  assign in_range_p0 = ({1'b0, gnt_idx_p0} < NF_LIM);

  // Stage 1: apply the granted command or the current sweep step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      flag_q     <= '0;
      cmd_valid  <= 1'b0;
      cmd_op     <= 1'b0;
      cmd_idx    <= '0;
      err_idx    <= 1'b0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      err_idx    <= 1'b0;
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (sweep_start) begin
            state      <= SWEEP;
            cnt        <= '0;
            sweep_busy <= 1'b1;
          end else if (vld_p0) begin
            ptr <= (gnt_id_p0 == LAST_R) ? '0 : gnt_id_p0 + 1'b1;
            if (in_range_p0) begin
              flag_q[gnt_idx_p0] <= gnt_op_p0;
              cmd_valid          <= 1'b1;
              cmd_op             <= gnt_op_p0;
              cmd_idx            <= gnt_idx_p0;
            end else begin
              err_idx <= 1'b1;
            end
          end
        end
        SWEEP: begin
          flag_q[cnt] <= 1'b0;
          cmd_valid   <= 1'b1;
          cmd_op      <= 1'b0;
          cmd_idx     <= cnt;
          if (cnt == LAST) begin
            state      <= IDLE;
            cnt        <= '0;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Shared bank of NFLAG set/reset status flags, each with SR flip-flop semantics, written by NREQ independent requesters.
- Round-robin arbiter serializes requests to one set-or-clear command per cycle. Conflicting set/clear requests from different requesters are therefore ordered, and the invalid S=R=1 condition can never occur.
- A sweep sequencer clears the whole bank, one flag per cycle, on demand.
- Sits between control agents (interrupt sources, handshake monitors) and the status flags they share.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NFLAG, 8, number of flags in the bank (2..16)
- IW, 3, index width; must satisfy 2**IW >= NFLAG

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  per-requester command valid
- req_op  input  NREQ  per-requester operation: 1 = set, 0 = clear
- req_idx  input  NREQ*IW  per-requester flag index; requester i uses bits [i*IW +: IW]
- req_ready  output  NREQ  one-hot grant (combinational); transfer occurs when valid&ready
- sweep_start  input  1  request a clear of the full bank
- sweep_busy  output  1  high while the sweep is in progress
- sweep_done  output  1  one-cycle pulse after the last flag is cleared
- flag_q  output  NFLAG  flag state (registered)
- cmd_valid  output  1  registered: a command was applied at the last edge
- cmd_op  output  1  registered op of the applied command
- cmd_idx  output  IW  registered index of the applied command
- err_idx  output  1  registered one-cycle pulse: granted command had req_idx >= NFLAG

Behaviour:
- Reset (async, rst=1) forces:
  - flag_q=0, cmd_valid=0, cmd_op=0, cmd_idx=0, err_idx=0, sweep_busy=0, sweep_done=0
  - RR pointer=0, state=IDLE, sweep counter=0
  - req_ready=0 while rst is high
- States: IDLE, SWEEP.
- IDLE arbitration:
  - Search starts at the RR pointer and wraps modulo NREQ.
  - The first requester with req_valid=1 receives req_ready=1; all others get 0.
  - No valid requester: req_ready=0 and the pointer holds.
  - If sweep_start=1 in the same cycle, req_ready=0 for all requesters. Sweep has priority.
- Grant effect at the next edge (single-cycle latency):
  - op=1 sets flag_q[idx]; op=0 clears flag_q[idx].
  - cmd_valid=1, with cmd_op and cmd_idx capturing the command.
  - RR pointer becomes (granted+1) mod NREQ.
- Setting a flag that is already 1, or clearing one that is already 0: no change to flag_q, but cmd_valid still pulses (hold case).
- Out-of-range index (idx >= NFLAG):
  - The command is still granted and the pointer advances.
  - flag_q is unchanged, cmd_valid=0, err_idx=1 for one cycle.
- No grant in a cycle: cmd_valid=0, err_idx=0.
- IDLE->SWEEP on sweep_start=1: counter=0, sweep_busy=1 from the next cycle.
- SWEEP:
  - Each cycle clears flag_q[counter], sets cmd_valid=1, cmd_op=0, cmd_idx=counter, then increments the counter.
  - req_ready=0 throughout; requesters hold their valid and retry after the sweep.
  - sweep_start is ignored.
  - At counter=NFLAG-1: the clear is applied, state returns to IDLE, sweep_busy falls and sweep_done=1 for one cycle.
  - Total duration is NFLAG cycles of sweep_busy.
  - Arbitration resumes in the cycle sweep_done is high.
  - The RR pointer is unchanged by a sweep.
- Invariant: at most one flag changes per cycle. Across a valid/ready transfer, req_op and req_idx must be stable only in the transfer cycle.
- Reset during SWEEP: the sweep aborts immediately, all flags read 0, and no sweep_done is generated.

Test Plan:
1. Reset, then requester 2 asserts set idx5 alone -> req_ready=4'b0100 that cycle; next cycle flag_q=8'h20, cmd_valid=1, cmd_op=1, cmd_idx=5, pointer=3.
2. All four requesters valid from pointer=0 (req0 set 0, req1 set 1, req2 clear 0, req3 set 7), held until granted -> grants in order 0,1,2,3 on consecutive cycles; flag_q sequence 01, 03, 02, 82.
3. Conflict: req0 set idx3 and req1 clear idx3 together, pointer=1 -> req1 granted first (flag3 stays 0), then req0 (flag3=1); flag_q never shows X.
4. flag_q=8'hFF, pulse sweep_start while req0 is valid -> no grant that cycle; sweep_busy high for 8 cycles, clearing flags 0..7 in order; sweep_done pulses once; flag_q=0; req0 granted in the sweep_done cycle.
5. req1 set idx 6 with NFLAG=6 -> granted, flag_q unchanged, err_idx=1 for one cycle, cmd_valid=0, pointer=2.
6. Assert rst mid-sweep (counter=3) with flags partially set -> all outputs at reset values immediately; after release, state=IDLE and no sweep_done is observed.
